lfsr_burst_ctrl: RTL

Command-driven sequencer around a reconfigurable Fibonacci LFSR. It accepts one command at a time carrying tap mask, seed and burst length. It then streams that many LFSR states over a valid/ready output with backpressure. On completion it reports the measured sequence period, so software can check a tap configuration for maximal length. It sits between the test/config master and any consumer of pseudo-random words, and owns the LFSR register.

---
 rtl/lfsr_burst_ctrl_if.sv | 30 +++
 rtl/lfsr_burst_ctrl.sv | 106 ++++++++++
 2 files changed

// File: rtl/lfsr_burst_ctrl_if.sv
// Command and output-stream bundle for lfsr_burst_ctrl.
// slave is the sequencer side; master is the config master plus stream consumer.
interface lfsr_burst_ctrl_if #(
  parameter int WIDTH = 3,
  parameter int LEN_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_taps;
  logic [WIDTH-1:0] cmd_seed;
  logic [LEN_W-1:0] cmd_len;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             busy;
  logic             done;
  logic             err;
  logic [LEN_W-1:0] period;

  modport slave (
    input  cmd_valid, cmd_taps, cmd_seed, cmd_len, out_ready,
    output cmd_ready, out_valid, out_data, out_last, busy, done, err, period
  );

  modport master (
    output cmd_valid, cmd_taps, cmd_seed, cmd_len, out_ready,
    input  cmd_ready, out_valid, out_data, out_last, busy, done, err, period
  );
endinterface

// File: rtl/lfsr_burst_ctrl.sv
// Command-driven Fibonacci LFSR burst sequencer; first beat 2 cycles after accept, done 1 cycle after last beat.
// Output stalls hold data and LFSR state; commands are refused (cmd_ready=0) while busy or pulsing done/err.
module lfsr_burst_ctrl #(
  parameter int WIDTH = 3,
  parameter int LEN_W = 8
) (
  input logic              clk,
  input logic              reset,
  lfsr_burst_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, FIN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, taps_q, seed_q, lfsr_nxt;
  logic [LEN_W-1:0] len_q, cnt_q, step_q, step_inc, period_q;
  logic             seen_q, done_q, err_q;
  logic             cmd_rdy, o_vld, o_last, fin_done;
  logic             cmd_hs, beat_hs, bad_cfg;

  assign lfsr_nxt = {lfsr_q[WIDTH-2:0], ^(lfsr_q & taps_q)};
  assign step_inc = (&step_q) ? step_q : step_q + 1'b1;
  assign bad_cfg  = (bus.cmd_seed == '0) || (bus.cmd_taps == '0);
  assign cmd_hs   = bus.cmd_valid && cmd_rdy;
  assign beat_hs  = o_vld && bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    cmd_rdy  = 1'b0;
    o_vld    = 1'b0;
    o_last   = 1'b0;
    fin_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        // rejected and zero-length commands resolve in IDLE; block a new accept during their pulse
        cmd_rdy = !(done_q || err_q);
        if (bus.cmd_valid && cmd_rdy && !bad_cfg && (bus.cmd_len != '0)) state_d = LOAD;
      end
      LOAD: state_d = RUN;
      RUN: begin
        o_vld  = 1'b1;
        o_last = (cnt_q == LEN_W'(1));
        if (bus.out_ready && o_last) state_d = FIN;
      end
      FIN: begin
        fin_done = 1'b1;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q   <= '0;
      taps_q   <= '0;
      seed_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      step_q   <= '0;
      period_q <= '0;
      seen_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (cmd_hs) begin
        taps_q   <= bus.cmd_taps;
        seed_q   <= bus.cmd_seed;
        len_q    <= bus.cmd_len;
        period_q <= '0;
        seen_q   <= 1'b0;
        if (bad_cfg)                 err_q  <= 1'b1;
        else if (bus.cmd_len == '0)  done_q <= 1'b1;
      end
      if (state_q == LOAD) begin
        lfsr_q <= seed_q;
        cnt_q  <= len_q;
        step_q <= '0;
      end
      if (beat_hs) begin
        lfsr_q <= lfsr_nxt;
        cnt_q  <= cnt_q - 1'b1;
        step_q <= step_inc;
        // only the first return to the seed defines the period
        if ((lfsr_nxt == seed_q) && !seen_q) begin
          period_q <= step_inc;
          seen_q   <= 1'b1;
        end
      end
    end
  end

  assign bus.cmd_ready = cmd_rdy;
  assign bus.out_valid = o_vld;
  assign bus.out_data  = lfsr_q;
  assign bus.out_last  = o_last;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = fin_done || done_q;
  assign bus.err       = err_q;
  assign bus.period    = period_q;
endmodule
